alu_arbiter: RTL and testbench

Shares the single 32-bit ALU among NREQ requesters, e.g. the integer pipe, the address generator and the debug port. Requests are granted round-robin with valid/ready handshakes. The block drives the ALU operands and opcode, accounts for the ALU's one-cycle registered latency, captures result and zero flag, and returns them to the granted requester. One operation is in flight at a time.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu_arbiter_rr.sv | 29 ++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state, ALU opcodes, lock limit.
// The optional grant-lock feature is enabled by defining ALU_ARB_LOCK_EN.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    localparam int LOCK_MAX = 4;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    logic [IDW-1:0] w_j;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = IDW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-latency ALU among NREQ requesters, one op in flight.
// Optional sticky grants (req_lock port) are compiled in with ALU_ARB_LOCK_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int n    = 32,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]   req_lock,
`endif
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [n-1:0]      resp_result,
    output logic              resp_zero,
    output logic [n-1:0]      alu_a,
    output logic [n-1:0]      alu_b,
    output logic [2:0]        alu_control,
    input  logic [n-1:0]      alu_result,
    input  logic              alu_zero,
    output state_e            o_dbg_state
);

    // Handshakes: a request transfers on the edge where req_valid[i] and req_ready[i]
    // are both high (IDLE only); a response transfers when resp_valid[owner] and
    // resp_ready[owner] are both high (RESP only).
    state_e          r_state, w_next;
    logic [IDW-1:0]  r_ptr, r_owner;
    logic [IDW-1:0]  w_arb_idx, w_sel_idx;
    logic [NREQ-1:0] w_arb_gnt, w_sel_gnt;
    logic            w_accept, w_resp_hs;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

`ifdef ALU_ARB_LOCK_EN
    logic       r_lock_pend;
    logic [2:0] r_run;
    logic       w_relock;

    assign w_relock  = r_lock_pend && req_valid[r_owner];
    assign w_sel_idx = w_relock ? r_owner : w_arb_idx;
    assign w_sel_gnt = w_relock ? (NREQ'(1) << r_owner) : w_arb_gnt;

    // r_run counts consecutive grants to the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_pend <= 1'b0;
            r_run       <= '0;
        end else begin
            if (w_resp_hs)
                r_lock_pend <= req_lock[r_owner] && (r_run < 3'(LOCK_MAX));
            else if (r_state == IDLE)
                r_lock_pend <= 1'b0;
            if (w_accept)
                r_run <= w_relock ? r_run + 3'd1 : 3'd1;
        end
    end
`else
    assign w_sel_idx = w_arb_idx;
    assign w_sel_gnt = w_arb_gnt;
`endif

    assign w_accept    = (r_state == IDLE) && (|req_valid);
    assign w_resp_hs   = (r_state == RESP) && resp_ready[r_owner];
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (|req_valid) w_next = ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP:    if (resp_ready[r_owner]) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (r_state == IDLE) req_ready = w_sel_gnt;
        if (r_state == RESP) resp_valid[r_owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a       <= req_a[w_sel_idx*n +: n];
                alu_b       <= req_b[w_sel_idx*n +: n];
                alu_control <= req_op[w_sel_idx*3 +: 3];
                r_owner     <= w_sel_idx;
            end
            if (r_state == CAPTURE) begin
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
            end
            if (w_resp_hs)
                r_ptr <= (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + IDW'(1);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered ALU model behind the ALU ports.
// The sticky-grant sequence is included when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int n    = 32;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*n-1:0] req_a = '0;
    logic [NREQ*n-1:0] req_b = '0;
    logic [NREQ*3-1:0] req_op = '0;
`ifdef ALU_ARB_LOCK_EN
    logic [NREQ-1:0]   req_lock = '0;
`endif
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready = '1;
    logic [n-1:0]      resp_result;
    logic              resp_zero;
    logic [n-1:0]      alu_a, alu_b;
    logic [2:0]        alu_control;
    logic [n-1:0]      alu_result = '0;
    logic              alu_zero = 1'b0;
    state_e            dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.n(n), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
`ifdef ALU_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .o_dbg_state (dbg_state)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            ALU_ADD: alu_fn = a + b;
            ALU_SUB: alu_fn = a - b;
            ALU_AND: alu_fn = a & b;
            ALU_OR:  alu_fn = a | b;
            ALU_XOR: alu_fn = a ^ b;
            ALU_NOR: alu_fn = ~(a | b);
            ALU_SLL: alu_fn = b << a[4:0];
            default: alu_fn = $signed(b) >>> a[4:0];
        endcase
    endfunction

    // The ALU registers its result one edge after sampling operands.
    always @(posedge clk) begin
        alu_result <= alu_fn(alu_a, alu_b, alu_control);
        alu_zero   <= (alu_fn(alu_a, alu_b, alu_control) == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_a[id*n +: n]  = a;
        req_b[id*n +: n]  = b;
        req_op[id*3 +: 3] = op;
        req_valid[id]     = 1'b1;
    endtask

    task automatic wait_grant(input string tag, input int id, output int cyc);
        cyc = 0;
        #1;
        while (req_ready == '0 && cyc < 16) begin
            @(negedge clk); #1;
            cyc++;
        end
        check({tag, "_grant"}, 32'(req_ready), 32'(1) << id);
    endtask

    task automatic finish_resp(input string tag, input int id, input logic [31:0] er,
                               input logic ez);
        int c;
        c = 0;
        #1;
        while (resp_valid == '0 && c < 8) begin
            @(negedge clk); #1;
            c++;
        end
        check({tag, "_rvalid"}, 32'(resp_valid), 32'(1) << id);
        check({tag, "_result"}, resp_result, er);
        check({tag, "_zero"}, 32'(resp_zero), 32'(ez));
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input int id, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] er, input logic ez);
        int cyc;
        int lat;
        set_req(id, a, b, op);
        wait_grant(tag, id, cyc);
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_alu_op"}, 32'(alu_control), 32'(op));
        lat = 1;
        while (resp_valid == '0 && lat < 8) begin
            check({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rvalid"}, 32'(resp_valid), 32'(1) << id);
        check({tag, "_result"}, resp_result, er);
        check({tag, "_zero"}, 32'(resp_zero), 32'(ez));
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int order[8];
        order = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_zero", 32'(resp_zero), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctl", 32'(alu_control), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_no_ready", 32'(req_ready), 32'd0);
        @(negedge clk);

        // Single operations
        run_op("add0", 0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0);
        run_op("sub2", 2, 32'd9, 32'd9, ALU_SUB, 32'd0, 1'b1);
        run_op("sra3", 3, 32'd4, 32'h8000_0000, ALU_SRA, 32'hF800_0000, 1'b0);

        // Round-robin with all requesters valid
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd10, ALU_ADD);
        for (int g = 0; g < 8; g++) begin
            wait_grant("rr", order[g], cyc);
            if (g > 0) check("rr_spacing", 32'(cyc), 32'd3);
            @(negedge clk);
        end
        req_valid = 4'b1010;
        wait_grant("rr_after3", 1, cyc);
        @(negedge clk);
        req_valid = '0;
        finish_resp("rr_after3", 1, 32'd12, 1'b0);

        // Response backpressure on requester 1
        resp_ready = 4'b1101;
        set_req(1, 32'h0000_F0F0, 32'h0000_FF00, ALU_AND);
        wait_grant("bp", 1, cyc);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(0, 32'd3, 32'd4, ALU_XOR);
        cyc = 0;
        #1;
        while (resp_valid == '0 && cyc < 8) begin
            @(negedge clk); #1;
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rvalid", 32'(resp_valid), 32'b0010);
            check("bp_result", resp_result, 32'h0000_F000);
            check("bp_zero", 32'(resp_zero), 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk); #1;
        end
        resp_ready = '1;
        @(negedge clk);
        wait_grant("bp_next", 0, cyc);
        check("bp_next_wait", 32'(cyc), 32'd0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        finish_resp("bp_next", 0, 32'd7, 1'b0);

        run_op("or2", 2, 32'h00FF_0000, 32'h0000_FF00, ALU_OR, 32'h00FF_FF00, 1'b0);

        // Reset during CAPTURE
        set_req(3, 32'd6, 32'd7, ALU_ADD);
        wait_grant("mid", 3, cyc);
        @(negedge clk);
        req_valid[3] = 1'b0;
        @(negedge clk);
        #1;
        check("mid_state", 32'(dbg_state), 32'(CAPTURE));
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        check("mid_rst_ctl", 32'(alu_control), 32'd0);
        check("mid_rst_result", resp_result, 32'd0);
        check("mid_rst_rvalid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("mid_no_resp", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        set_req(1, 32'd1, 32'd1, ALU_ADD);
        set_req(3, 32'd5, 32'd5, ALU_ADD);
        wait_grant("post_rst", 1, cyc);
        check("post_rst_wait", 32'(cyc), 32'd0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        finish_resp("post_rst", 1, 32'd2, 1'b0);
        wait_grant("post_rst3", 3, cyc);
        @(negedge clk);
        req_valid[3] = 1'b0;
        finish_resp("post_rst3", 3, 32'd10, 1'b0);

`ifdef ALU_ARB_LOCK_EN
        // Sticky grant for requester 0, capped at four consecutive grants
        order = '{0, 0, 0, 0, 1, 0, 0, 0};
        req_lock = 4'b0001;
        set_req(0, 32'd1, 32'd2, ALU_ADD);
        set_req(1, 32'd3, 32'd4, ALU_ADD);
        for (int g = 0; g < 5; g++) begin
            wait_grant("lock", order[g], cyc);
            @(negedge clk);
        end
        req_valid = '0;
        req_lock  = '0;
        finish_resp("lock_end", 1, 32'd7, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
